// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer, so that
// back-to-back words leave the block as one gapless bit stream.
module bit_serializer #(
   parameter int   WIDTH     = 8,
   parameter int   MSB_FIRST = 1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             dout,
   output logic             bit_valid,
   output logic             frame_last,
   output logic             busy
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] r_hold;
   logic [WIDTH-1:0] w_shifted;
   logic [CW-1:0]    r_cnt;
   logic             r_holdFull;
   logic             w_transfer;
   logic             w_lastBit;

   assign w_transfer = load_valid && !r_holdFull;
   assign w_lastBit  = (r_state == SHIFT) && (r_cnt == LAST);
   assign w_shifted  = (MSB_FIRST != 0) ? {r_sreg[WIDTH-2:0], 1'b0}
                                        : {1'b0, r_sreg[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Leave SHIFT only when the last bit goes out with nothing queued behind it.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_transfer) begin
               w_nextState = SHIFT;
            end
         end
         SHIFT: begin
            if (w_lastBit && !r_holdFull && !w_transfer) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sreg     <= '0;
         r_hold     <= '0;
         r_holdFull <= 1'b0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_transfer) begin
                  r_sreg <= data_in;
                  r_cnt  <= '0;
               end
            end
            SHIFT: begin
               if (w_lastBit) begin
                  r_cnt <= '0;
                  // The held word has priority; a fresh word may bypass the holding register.
                  if (r_holdFull) begin
                     r_sreg     <= r_hold;
                     r_holdFull <= 1'b0;
                  end else if (w_transfer) begin
                     r_sreg <= data_in;
                  end else begin
                     r_sreg <= w_shifted;
                  end
               end else begin
                  r_sreg <= w_shifted;
                  r_cnt  <= r_cnt + CW'(1);
                  if (w_transfer) begin
                     r_hold     <= data_in;
                     r_holdFull <= 1'b1;
                  end
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   always_comb begin
      dout       = IDLE_BIT;
      bit_valid  = 1'b0;
      frame_last = 1'b0;
      if (r_state == SHIFT) begin
         dout       = (MSB_FIRST != 0) ? r_sreg[WIDTH-1] : r_sreg[0];
         bit_valid  = 1'b1;
         frame_last = (r_cnt == LAST);
      end
      busy       = (r_state == SHIFT) || r_holdFull;
      load_ready = !r_holdFull;
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share one
// stimulus stream and are checked against a bit-queue reference model.
module tb_bit_serializer;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] dataIn = '0;
   logic             loadValid = 1'b0;

   logic loadReadyM, doutM, bitValidM, frameLastM, busyM;
   logic loadReadyL, doutL, bitValidL, frameLastL, busyL;

   int errors = 0;
   int checks = 0;

   logic [1:0] expQM[$];
   logic [1:0] expQL[$];
   int         pending = 0;
   int         accCount = 0;

   logic       detActive = 1'b0;
   logic [3:0] detHist = '0;
   int         detIdx = 0;
   int         detHits[$];

   bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1), .IDLE_BIT(1'b0)) uM (
      .clk(clk), .rst(rst), .data_in(dataIn), .load_valid(loadValid),
      .load_ready(loadReadyM), .dout(doutM), .bit_valid(bitValidM),
      .frame_last(frameLastM), .busy(busyM)
   );

   bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0), .IDLE_BIT(1'b0)) uL (
      .clk(clk), .rst(rst), .data_in(dataIn), .load_valid(loadValid),
      .load_ready(loadReadyL), .dout(doutL), .bit_valid(bitValidL),
      .frame_last(frameLastL), .busy(busyL)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each accepted word becomes WIDTH queued bits; the
   // block can take a new word while at most one word's worth is outstanding.
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            expQM.delete();
            expQL.delete();
            pending = 0;
         end else begin
            automatic logic acc = loadValid && (pending <= WIDTH);
            if (pending > 0) pending--;
            if (acc) begin
               for (int i = 0; i < WIDTH; i++) begin
                  expQM.push_back({(i == WIDTH-1) ? 1'b1 : 1'b0, dataIn[WIDTH-1-i]});
                  expQL.push_back({(i == WIDTH-1) ? 1'b1 : 1'b0, dataIn[i]});
               end
               pending += WIDTH;
               accCount++;
            end
         end
      end
   end

   // Monitor: compares every cycle, popping expected bits whenever a DUT presents one.
   initial begin
      forever begin
         @(negedge clk);
         checkOutput("bitValidM", bitValidM, pending > 0);
         checkOutput("bitValidL", bitValidL, pending > 0);
         checkOutput("busyM", busyM, pending > 0);
         checkOutput("busyL", busyL, pending > 0);
         checkOutput("loadReadyM", loadReadyM, pending <= WIDTH);
         checkOutput("loadReadyL", loadReadyL, pending <= WIDTH);
         if (bitValidM) begin
            if (expQM.size() == 0) begin
               checkOutput("underflowM", 1, 0);
            end else begin
               automatic logic [1:0] e = expQM.pop_front();
               checkOutput("doutM", doutM, e[0]);
               checkOutput("frameLastM", frameLastM, e[1]);
            end
            if (detActive) begin
               detHist = {detHist[2:0], doutM};
               if (detIdx >= 3 && detHist == 4'b1010) detHits.push_back(detIdx);
               detIdx++;
            end
         end else begin
            checkOutput("idleDoutM", doutM, 0);
            checkOutput("idleFrameLastM", frameLastM, 0);
         end
         if (bitValidL) begin
            if (expQL.size() == 0) begin
               checkOutput("underflowL", 1, 0);
            end else begin
               automatic logic [1:0] e = expQL.pop_front();
               checkOutput("doutL", doutL, e[0]);
               checkOutput("frameLastL", frameLastL, e[1]);
            end
         end else begin
            checkOutput("idleDoutL", doutL, 0);
            checkOutput("idleFrameLastL", frameLastL, 0);
         end
      end
   end

   task automatic applyStimulus(input logic [WIDTH-1:0] w);
      automatic int  startAcc = accCount;
      automatic bit  done = 0;
      dataIn    = w;
      loadValid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clk);
         #1;
         if (accCount != startAcc) done = 1;
      end
      if (!done) checkOutput("acceptTimeout", 0, 1);
   endtask

   task automatic waitIdle();
      loadValid = 1'b0;
      for (int i = 0; i < 100 && pending != 0; i++) @(posedge clk);
      if (pending != 0) checkOutput("drainTimeout", pending, 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b0;
      loadValid = 1'b1;
      dataIn    = WIDTH'($urandom);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetAccepts", accCount, 0);
      rst       = 1'b1;
      loadValid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      applyStimulus(8'hA5);
      waitIdle();

      detActive = 1'b1;
      detIdx    = 0;
      detHist   = '0;
      applyStimulus(8'h0A);
      applyStimulus(8'hA0);
      waitIdle();
      detActive = 1'b0;
      checkOutput("detHitCount", detHits.size(), 3);
      if (detHits.size() >= 3) begin
         checkOutput("detHit0", detHits[0], 7);
         checkOutput("detHit1", detHits[1], 9);
         checkOutput("detHit2", detHits[2], 11);
      end

      applyStimulus(8'h3C);
      applyStimulus(8'hC3);
      applyStimulus(8'h96);
      waitIdle();

      for (int n = 0; n < 40; n++) begin
         applyStimulus(WIDTH'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            loadValid = 1'b0;
            repeat ($urandom_range(1, 12)) @(posedge clk);
            #1;
         end
      end
      waitIdle();

      applyStimulus(8'hFF);
      applyStimulus(WIDTH'($urandom));
      loadValid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("asyncRstDout", doutM, 0);
      checkOutput("asyncRstBitValid", bitValidM, 0);
      checkOutput("asyncRstFrameLast", frameLastM, 0);
      checkOutput("asyncRstBusy", busyM, 0);
      checkOutput("asyncRstReady", loadReadyM, 1);
      checkOutput("asyncRstBusyL", busyL, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;

      applyStimulus(8'h5A);
      waitIdle();
      checkOutput("leftoverM", expQM.size(), 0);
      checkOutput("leftoverL", expQL.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
